// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock controller and the downstream scan/decode path:
// mode encodings, field limits and blank-mask patterns.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    // bit0 hour tens, bit1 hour units, bit2 min tens, bit3 min units
    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HOUR = 4'b0011;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;

    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int NUM_BTN  = 2;

    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
        return (val == max_val) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and time/display outputs of the clock controller.
// The controller is the slave; the board/testbench side is the master.
interface clock_set_ctrl_if;
    import clock_set_ctrl_pkg::*;

    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       tick_1hz;
    logic [3:0] blank_mask;
    mode_e      mode;

    modport master (
        output btn_mode, btn_inc,
        input  hour, minutes, seconds, tick_1hz, blank_mask, mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output hour, minutes, seconds, tick_1hz, blank_mask, mode
    );

endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted press (debounced 0->1); releases produce nothing.
module clock_set_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // The counter only advances while the synchronised input disagrees with the
    // accepted level; any agreeing cycle restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS timekeeper with a RUN/SET_HOUR/SET_MIN button-driven editor,
// 1 Hz prescaler, blink timer for the field being edited and idle auto-return.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int BLINK_HALF_CYC = 25_000_000,
    parameter int SET_TIMEOUT_S  = 10
) (
    input  logic            clk,
    input  logic            rst,
    clock_set_ctrl_if.slave bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;
    localparam int IW = $clog2(SET_TIMEOUT_S + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(SET_TIMEOUT_S - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw[BTN_MODE] = bus.btn_mode;
    assign btn_raw[BTN_INC]  = bus.btn_inc;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        clock_set_ctrl_btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[gi]),
            .press   (btn_press[gi])
        );
    end

    mode_e         state_q, state_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [3:0]    blank_q, blank_d;
    logic          blink_restart;

    always_comb begin
        state_d       = state_q;
        hour_d        = hour_q;
        minutes_d     = minutes_q;
        seconds_d     = seconds_q;
        idle_d        = idle_q;
        tick_d        = (presc_q == PRESC_LAST);
        presc_d       = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        blank_d       = BLANK_NONE;
        blink_restart = 1'b0;

        unique case (state_q)
            MODE_RUN: begin
                idle_d = '0;
                if (tick_q) begin
                    seconds_d = wrap_inc(seconds_q, MAX_SEC);
                    if (seconds_q == MAX_SEC) begin
                        minutes_d = wrap_inc(minutes_q, MAX_MIN);
                        if (minutes_q == MAX_MIN) begin
                            hour_d = 5'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}));
                        end
                    end
                end
                if (btn_press[BTN_MODE]) begin
                    state_d = MODE_SET_HOUR;
                end
            end
            MODE_SET_HOUR, MODE_SET_MIN: begin
                // MODE has priority; a coincident INC pulse is dropped.
                if (btn_press[BTN_MODE]) begin
                    idle_d = '0;
                    if (state_q == MODE_SET_HOUR) begin
                        state_d = MODE_SET_MIN;
                    end else begin
                        state_d   = MODE_RUN;
                        seconds_d = '0;
                        presc_d   = '0;
                    end
                end else if (btn_press[BTN_INC]) begin
                    idle_d = '0;
                    if (state_q == MODE_SET_HOUR) begin
                        hour_d = 5'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}));
                    end else begin
                        minutes_d = wrap_inc(minutes_q, MAX_MIN);
                    end
                end else if (tick_q) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = MODE_RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = MODE_RUN;
            end
        endcase

        // Restarting on every edit keeps the edited digits visible right after a press.
        blink_restart = (state_d != state_q) || btn_press[BTN_INC];
        if (blink_restart) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        if (blink_phase_d) begin
            unique case (state_d)
                MODE_SET_HOUR: blank_d = BLANK_HOUR;
                MODE_SET_MIN:  blank_d = BLANK_MIN;
                default:       blank_d = BLANK_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MODE_RUN;
            hour_q        <= '0;
            minutes_q     <= '0;
            seconds_q     <= '0;
            presc_q       <= '0;
            tick_q        <= 1'b0;
            idle_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blank_q       <= BLANK_NONE;
        end else begin
            state_q       <= state_d;
            hour_q        <= hour_d;
            minutes_q     <= minutes_d;
            seconds_q     <= seconds_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            idle_q        <= idle_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blank_q       <= blank_d;
        end
    end

    assign bus.hour       = hour_q;
    assign bus.minutes    = minutes_q;
    assign bus.seconds    = seconds_q;
    assign bus.tick_1hz   = tick_q;
    assign bus.blank_mask = blank_q;
    assign bus.mode       = state_q;

endmodule
